// File: rtl/fp_pkg.sv
// Shared constants, types and helpers for the iterative FP divider.
package fp_pkg;

   localparam logic [2:0] FUNC_DIV = 3'b011;
   localparam logic [2:0] FUNC_INV = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_NORM,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } class_e;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
      logic div_by_zero;
      logic qnan;
      logic snan;
   } flags_t;

   // Exponent bias for a given exponent width.
   function automatic int unsigned fp_bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 1)) - 32'd1;
   endfunction

   // Canonical quiet NaN {0, all-ones exponent, 1, 0...} right-aligned in 128 bits.
   function automatic logic [127:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
      logic [127:0] r;
      r = '0;
      r[man_w-1] = 1'b1;
      for (int unsigned i = 0; i < exp_w; i++) begin
         r[man_w+i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational decode of one IEEE-754 operand; subnormals flush to signed zero.
module fp_classify
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] num,
   output class_e               cls,
   output logic                 sign,
   output logic [EXP_W-1:0]     exp,
   output logic [MAN_W-1:0]     frac
);

   // Split fields and classify; zero exponent means zero or flushed subnormal.
   always_comb begin
      sign = num[EXP_W+MAN_W];
      exp  = num[EXP_W+MAN_W-1:MAN_W];
      frac = num[MAN_W-1:0];
      cls  = CLS_NORM;
      if (exp == '1) begin
         if (frac == '0)          cls = CLS_INF;
         else if (frac[MAN_W-1])  cls = CLS_QNAN;
         else                     cls = CLS_SNAN;
      end else if (exp == '0) begin
         cls  = CLS_ZERO;
         frac = '0;
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider / reciprocal: radix-2 restoring mantissa division,
// round-to-nearest-even, valid/ready handshake on input and output.
module fp_div_iter
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           func,
   input  logic [EXP_W+MAN_W:0] num1,
   input  logic [EXP_W+MAN_W:0] num2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact,
   output logic                 div_by_zero,
   output logic                 QNaN,
   output logic                 SNaN
);

   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned QW    = MAN_W + 3;
   localparam int unsigned CNT_W = $clog2(QW);

   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(QW - 1);
   localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(fp_bias(EXP_W));
   localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] ONE_S   = (EXP_W+2)'(1);
   localparam logic signed [EXP_W+1:0] ZERO_S  = '0;
   localparam logic [W-1:0]           QNAN_C   = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic [W-1:0]           ONE_C    = {1'b0, BIAS_S[EXP_W-1:0], {MAN_W{1'b0}}};

   // Operand selection: INV computes +1.0 / num1
   logic           inv_op;
   logic [W-1:0]   op_a, op_b;
   class_e         cls_a, cls_b;
   logic           sgn_a, sgn_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] frc_a, frc_b;

   assign inv_op = (func == FUNC_INV);
   assign op_a   = inv_op ? ONE_C : num1;
   assign op_b   = inv_op ? num1  : num2;

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .num (op_a), .cls (cls_a), .sign (sgn_a), .exp (exp_a), .frac (frc_a)
   );

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .num (op_b), .cls (cls_b), .sign (sgn_b), .exp (exp_b), .frac (frc_b)
   );

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [EXP_W+1:0] exp_q, exp_d;
   logic [QW-1:0]           quo_q, quo_d;
   logic [MAN_W+1:0]        rem_q, rem_d;
   logic [MAN_W:0]          div_q, div_d;
   logic                    sign_q, sign_d;
   logic                    spec_q, spec_d;
   logic [W-1:0]            spec_res_q, spec_res_d;
   flags_t                  spec_flg_q, spec_flg_d;
   logic [W-1:0]            result_q, result_d;
   flags_t                  flags_q, flags_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;

   // Normalise, round (RNE) and range-check the finished quotient
   logic [W-1:0]            norm_res;
   flags_t                  norm_flg;
   logic [MAN_W:0]          mant;
   logic [MAN_W+1:0]        mant_sum;
   logic                    guard, rnd, sticky, round_up;
   logic signed [EXP_W+1:0] exp_n, exp_r;

   always_comb begin
      if (quo_q[QW-1]) begin
         mant  = quo_q[QW-1:2];
         guard = quo_q[1];
         rnd   = quo_q[0];
         exp_n = exp_q;
      end else begin
         // Shifting left leaves a zero round bit; the remainder still carries sticky
         mant  = quo_q[QW-2:1];
         guard = quo_q[0];
         rnd   = 1'b0;
         exp_n = exp_q - ONE_S;
      end
      sticky   = (rem_q != '0);
      round_up = guard & (rnd | sticky | mant[0]);
      mant_sum = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
      // Carry-out leaves fraction bits all zero, so only the exponent moves
      exp_r    = exp_n + $signed({{(EXP_W+1){1'b0}}, mant_sum[MAN_W+1]});
      norm_flg = '0;
      norm_flg.inexact = guard | rnd | sticky;
      if (exp_r >= EXP_MAX) begin
         norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         norm_flg.overflow = 1'b1;
         norm_flg.inexact  = 1'b1;
      end else if (exp_r <= ZERO_S) begin
         norm_res = {sign_q, {(W-1){1'b0}}};
         norm_flg.underflow = 1'b1;
         norm_flg.inexact   = 1'b1;
      end else begin
         norm_res = {sign_q, exp_r[EXP_W-1:0], mant_sum[MAN_W-1:0]};
      end
   end

   // Control FSM, special-case decode and one restoring-division step per CALC cycle
   logic             sgn_ab;
   logic             special;
   logic             rem_ge;
   logic [MAN_W+1:0] rem_n;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      div_d      = div_q;
      sign_d     = sign_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      spec_flg_d = spec_flg_q;
      result_d   = result_q;
      flags_d    = flags_q;
      sgn_ab     = sgn_a ^ sgn_b;
      special    = 1'b1;
      rem_ge     = (rem_q >= {1'b0, div_q});
      rem_n      = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sign_d     = sgn_ab;
               exp_d      = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S;
               rem_d      = {1'b0, 1'b1, frc_a};
               div_d      = {1'b1, frc_b};
               quo_d      = '0;
               cnt_d      = '0;
               spec_res_d = '0;
               spec_flg_d = '0;
               if (func != FUNC_DIV && func != FUNC_INV) begin
                  spec_res_d      = QNAN_C;
                  spec_flg_d.qnan = 1'b1;
               end else if (cls_a == CLS_SNAN || cls_b == CLS_SNAN) begin
                  spec_res_d      = QNAN_C;
                  spec_flg_d.snan = 1'b1;
               end else if (cls_a == CLS_QNAN || cls_b == CLS_QNAN) begin
                  spec_res_d      = QNAN_C;
                  spec_flg_d.qnan = 1'b1;
               end else if ((cls_a == CLS_INF && cls_b == CLS_INF) ||
                            (cls_a == CLS_ZERO && cls_b == CLS_ZERO)) begin
                  spec_res_d      = QNAN_C;
                  spec_flg_d.qnan = 1'b1;
               end else if (cls_b == CLS_ZERO) begin
                  spec_res_d             = {sgn_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  spec_flg_d.div_by_zero = 1'b1;
               end else if (cls_a == CLS_INF) begin
                  spec_res_d = {sgn_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
                  spec_res_d = {sgn_ab, {(W-1){1'b0}}};
               end else begin
                  special = 1'b0;
               end
               spec_d  = special;
               state_d = special ? ST_NORM : ST_CALC;
            end
         end
         ST_CALC: begin
            quo_d = {quo_q[QW-2:0], rem_ge};
            rem_d = {rem_n[MAN_W:0], 1'b0};
            if (cnt_q == CNT_LAST) state_d = ST_NORM;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_NORM: begin
            result_d = spec_q ? spec_res_q : norm_res;
            flags_d  = spec_q ? spec_flg_q : norm_flg;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         exp_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         sign_q      <= 1'b0;
         spec_q      <= 1'b0;
         spec_res_q  <= '0;
         spec_flg_q  <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exp_q       <= exp_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         div_q       <= div_d;
         sign_q      <= sign_d;
         spec_q      <= spec_d;
         spec_res_q  <= spec_res_d;
         spec_flg_q  <= spec_flg_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign overflow    = flags_q.overflow;
   assign underflow   = flags_q.underflow;
   assign inexact     = flags_q.inexact;
   assign div_by_zero = flags_q.div_by_zero;
   assign QNaN        = flags_q.qnan;
   assign SNaN        = flags_q.snan;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter (single precision).
module tb_fp_div_iter;

   localparam logic [2:0] F_DIV = 3'b011;
   localparam logic [2:0] F_INV = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  func;
   logic [31:0] num1, num2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow, underflow, inexact, div_by_zero, QNaN, SNaN;
   logic [5:0]  flg;

   int checks = 0;
   int errors = 0;

   assign flg = {overflow, underflow, inexact, div_by_zero, QNaN, SNaN};

   always #5 clk = ~clk;

   fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .func        (func),
      .num1        (num1),
      .num2        (num2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .overflow    (overflow),
      .underflow   (underflow),
      .inexact     (inexact),
      .div_by_zero (div_by_zero),
      .QNaN        (QNaN),
      .SNaN        (SNaN)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one operation; returns #1 after the accept edge with in_valid dropped.
   task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      func     = f;
      num1     = a;
      num2     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      num1     = $urandom;
      num2     = $urandom;
      func     = 3'b111;
   endtask

   // Count edges until out_valid, bounded.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Check latency, result and flags, then complete the output handshake.
   task automatic finish(input string tag, input int lat_exp,
                         input logic [31:0] r_exp, input logic [5:0] f_exp);
      int lat;
      wait_valid(lat);
      chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, " result"}, result, r_exp);
      chk({tag, " flags"}, {26'd0, flg}, {26'd0, f_exp});
      chk({tag, " in_ready in DONE"}, {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, " out_valid after hs"}, {31'd0, out_valid}, 32'd0);
      chk({tag, " in_ready after hs"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      func      = 3'b000;
      num1      = '0;
      num2      = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst result", result, 32'h0);
      chk("rst flags", {26'd0, flg}, 32'd0);

      // Normal divisions and reciprocal
      start(F_DIV, 32'h41040000, 32'h3FC00000);
      finish("div 8.25/1.5", 27, 32'h40B00000, 6'b000000);
      start(F_DIV, 32'hC1040000, 32'hBFA00000);
      finish("div -8.25/-1.25", 27, 32'h40D33333, 6'b001000);
      start(F_INV, 32'h40000000, 32'h12345678);
      finish("inv 2.0", 27, 32'h3F000000, 6'b000000);
      start(F_DIV, 32'h3F800000, 32'h40400000);
      finish("div 1/3", 27, 32'h3EAAAAAB, 6'b001000);

      // Special cases
      start(F_DIV, 32'h41040000, 32'h00000000);
      finish("div x/0", 1, 32'h7F800000, 6'b000100);
      start(F_DIV, 32'h7F800000, 32'hFF800000);
      finish("div inf/inf", 1, 32'h7FC00000, 6'b000010);
      start(F_DIV, 32'h7F800001, 32'h3F800000);
      finish("div snan", 1, 32'h7FC00000, 6'b000001);
      start(F_DIV, 32'h80000000, 32'h00000000);
      finish("div 0/0", 1, 32'h7FC00000, 6'b000010);
      start(F_DIV, 32'h80000001, 32'h3F800000);
      finish("div subnormal/1", 1, 32'h80000000, 6'b000000);
      start(3'b000, 32'h3F800000, 32'h3F800000);
      finish("bad func", 1, 32'h7FC00000, 6'b000010);

      // Range limits
      start(F_DIV, 32'hFF040000, 32'h00C00000);
      finish("overflow", 27, 32'hFF800000, 6'b101000);
      start(F_DIV, 32'h00C00000, 32'h7F000000);
      finish("underflow", 27, 32'h00000000, 6'b011000);

      // Backpressure with a waiting request
      start(F_DIV, 32'hC1040000, 32'hBFA00000);
      wait_valid(lat);
      chk("bp latency", 32'(lat), 32'd27);
      func     = F_INV;
      num1     = 32'h40000000;
      num2     = 32'h0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp out_valid held", {31'd0, out_valid}, 32'd1);
         chk("bp result held", result, 32'h40D33333);
         chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp out_valid after hs", {31'd0, out_valid}, 32'd0);
      chk("bp in_ready after hs", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp held req accepted", {31'd0, in_ready}, 32'd0);
      finish("bp inv 2.0", 27, 32'h3F000000, 6'b000000);

      // Reset during CALC
      start(F_DIV, 32'hC1040000, 32'hBFA00000);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort flags", {26'd0, flg}, 32'd0);
      chk("abort result", result, 32'h0);
      start(F_DIV, 32'h41040000, 32'h3FC00000);
      finish("post-abort div", 27, 32'h40B00000, 6'b000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
